// File: rtl/sram_pattern_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_pattern_gen_if
//  Purpose  : Bundles the control, pattern and compare-result signals that
//             pass between the pattern generator and the SRAM test harness.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_pattern_gen_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        mode_i;
  logic              r_i;
  logic [DATA_W-1:0] d_o;
  logic [ADDR_W-1:0] addr_o;
  logic              cs_o;
  logic              we_o;
  logic              rd_o;
  logic              busy_o;
  logic              done_o;
  logic [ADDR_W:0]   err_cnt_o;
  logic              fail_o;

  // Harness / testbench side: drives requests and compare results.
  modport master (
    output start_i, mode_i, r_i,
    input  d_o, addr_o, cs_o, we_o, rd_o, busy_o, done_o, err_cnt_o, fail_o
  );

  // Generator side.
  modport slave (
    input  start_i, mode_i, r_i,
    output d_o, addr_o, cs_o, we_o, rd_o, busy_o, done_o, err_cnt_o, fail_o
  );
endinterface
`default_nettype wire

// File: rtl/sram_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : sram_pattern_gen
//  Purpose  : Writes a selectable pattern over the whole SRAM, reads it back
//             with the same pattern on d_o, and counts comparator mismatches
//             arriving CMP_LAT cycles after each read.
//  Revision : 1.0  initial release
// ============================================================================
module sram_pattern_gen #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 32,
  parameter int          CMP_LAT = 2,
  parameter logic [31:0] SEED    = 32'hA5A5_0001
) (
  input  wire              clk,
  input  wire              rst,
  sram_pattern_gen_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [31:0]   LFSR_MASK = 32'h8020_0003;
  localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        lfsr_q, lfsr_d;
  logic [1:0]         mode_q, mode_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [CMP_LAT-1:0] win_q, win_d;
  logic [ADDR_W:0]    err_q, err_d;
  logic               fail_q, fail_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               we_q, we_d, rd_q, rd_d, cs_q, cs_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic addr_last;
  logic drain_last;

  assign addr_last  = &addr_q;
  assign drain_last = (cnt_q == 3'(CMP_LAT - 1));

  // Galois LFSR, shift right; feedback taps applied when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

  // Data word for a given mode, address and LFSR state.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [31:0] l);
    logic [DATA_W-1:0] p;
    case (m)
      2'b00: p = DATA_W'(a);
      2'b01: begin
        // Even address: ...1010 (bit i = i[0]); odd address: ...0101.
        for (int i = 0; i < DATA_W; i++) p[i] = a[0] ? ~i[0] : i[0];
      end
      2'b10: p = DATA_W'(l);
      default: p = '1;
    endcase
    return p;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed-length WRITE / GAP / READ / DRAIN walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_WRITE;
      S_WRITE: if (addr_last)   state_d = S_GAP;
      S_GAP:                    state_d = S_READ;
      S_READ:  if (addr_last)   state_d = S_DRAIN;
      S_DRAIN: if (drain_last)  state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are decoded from the next state so
  // they line up with the state register once flopped.
  always_comb begin
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    mode_d = mode_q;
    cnt_d  = 3'd0;
    err_d  = err_q;
    fail_d = fail_q;

    // The oldest bit of the window marks the cycle a read result is valid.
    if (win_q[CMP_LAT-1] && bus.r_i && (err_q != ERR_MAX)) begin
      err_d  = err_q + (ADDR_W+1)'(1);
      fail_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          mode_d = bus.mode_i;
          addr_d = '0;
          lfsr_d = SEED;
          err_d  = '0;
          fail_d = 1'b0;
        end
      end
      S_WRITE, S_READ: begin
        if (addr_last) begin
          addr_d = '0;
          lfsr_d = SEED;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          lfsr_d = lfsr_step(lfsr_q);
        end
      end
      S_GAP: begin
        addr_d = '0;
        lfsr_d = SEED;
      end
      S_DRAIN: cnt_d = cnt_q + 3'd1;
      default: ;
    endcase

    win_d    = win_q << 1;
    win_d[0] = rd_q;

    we_d   = (state_d == S_WRITE);
    rd_d   = (state_d == S_READ);
    busy_d = (state_d == S_WRITE) || (state_d == S_GAP) ||
             (state_d == S_READ)  || (state_d == S_DRAIN);
    cs_d   = busy_d;
    done_d = (state_d == S_DONE);
    dout_d = (we_d || rd_d) ? pattern(mode_d, addr_d, lfsr_d) : '0;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lfsr_q <= SEED;
      mode_q <= 2'b00;
      cnt_q  <= 3'd0;
      win_q  <= '0;
      err_q  <= '0;
      fail_q <= 1'b0;
      dout_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= 1'b0;
      cs_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      win_q  <= win_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      dout_q <= dout_d;
      we_q   <= we_d;
      rd_q   <= rd_d;
      cs_q   <= cs_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.d_o       = dout_q;
  assign bus.addr_o    = addr_q;
  assign bus.cs_o      = cs_q;
  assign bus.we_o      = we_q;
  assign bus.rd_o      = rd_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.err_cnt_o = err_q;
  assign bus.fail_o    = fail_q;

endmodule
`default_nettype wire
